sme_match_scheduler: RTL

Front-end controller of the parallel string-matching engine. It takes the host byte stream, sequences string and pattern bytes into `shared_memory` through its write/select port, and tracks string and pattern lengths. It then schedules candidate match offsets across `NUM_SLAVE` compare slaves in rounds and arbitrates their hits, reporting the lowest matching offset.

---
 rtl/sme_pkg.sv | 29 ++
 rtl/sme_hit_arbiter.sv | 52 +++++
 rtl/sme_match_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sme_pkg.sv
// Shared constants and types for the string-matching engine front end:
// field widths, scheduler state encoding and shared_memory select codes.
package sme_pkg;

    localparam int BYTE        = 8;
    localparam int NUM_SLAVE   = 4;
    localparam int MAX_STRING  = 32;
    localparam int MAX_STR_ADD = 5;
    localparam int MAX_PATTERN = 8;
    localparam int MAX_PAT_ADD = 3;

    // Counter-width views of the capacities and of one scheduling round.
    localparam logic [MAX_STR_ADD:0] STR_FULL   = (MAX_STR_ADD + 1)'(MAX_STRING);
    localparam logic [MAX_PAT_ADD:0] PAT_FULL   = (MAX_PAT_ADD + 1)'(MAX_PATTERN);
    localparam logic [MAX_STR_ADD:0] ROUND_STEP = (MAX_STR_ADD + 1)'(NUM_SLAVE);

    localparam logic MEM_SEL_STR = 1'b0;
    localparam logic MEM_SEL_PAT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_STR,
        ST_LOAD_PAT,
        ST_LAUNCH,
        ST_WAIT,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/sme_hit_arbiter.sv
// Collects per-slave done/hit pulses for one round, flags when every enabled
// slave has finished, and picks the lowest-index hitting slave.
module sme_hit_arbiter
    import sme_pkg::*;
#(
    parameter int N_SLV = NUM_SLAVE,
    parameter int IDX_W = $clog2(N_SLV)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             collect,
    input  logic [N_SLV-1:0] en,
    input  logic [N_SLV-1:0] done,
    input  logic [N_SLV-1:0] hit,
    output logic             all_done,
    output logic             any_hit,
    output logic [IDX_W-1:0] hit_idx
);

    logic [N_SLV-1:0] done_sticky;
    logic [N_SLV-1:0] hit_sticky;
    logic [N_SLV-1:0] done_seen;
    logic [N_SLV-1:0] hit_seen;

    // Current-cycle pulses are merged in so the round can close on the same
    // edge that the final done arrives.
    assign done_seen = done_sticky | (collect ? (done & en) : '0);
    assign hit_seen  = hit_sticky  | (collect ? (done & hit & en) : '0);
    assign all_done  = collect && (&(done_seen | ~en));
    assign any_hit   = |hit_seen;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset || clear) begin
            done_sticky <= '0;
            hit_sticky  <= '0;
        end else if (collect) begin
            done_sticky <= done_seen;
            hit_sticky  <= hit_seen;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves hit_idx unassigned (no latch).
        hit_idx = '0;
        for (int k = N_SLV - 1; k >= 0; k--) begin
            if (hit_seen[k]) hit_idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/sme_match_scheduler.sv
// Front-end controller: loads string/pattern bytes into shared_memory, then
// schedules candidate offsets over the compare slaves round by round.
module sme_match_scheduler
    import sme_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_is_str,
    input  logic                             in_is_pat,
    input  logic [BYTE-1:0]                  in_char,
    output logic                             in_ready,
    output logic                             mem_write,
    output logic                             mem_sel,
    output logic [BYTE-1:0]                  mem_data,
    output logic [MAX_STR_ADD:0]             str_len,
    output logic [MAX_PAT_ADD:0]             pat_len,
    output logic                             slv_start,
    output logic [NUM_SLAVE-1:0]             slv_en,
    output logic [NUM_SLAVE*MAX_STR_ADD-1:0] slv_offset,
    input  logic [NUM_SLAVE-1:0]             slv_done,
    input  logic [NUM_SLAVE-1:0]             slv_hit,
    output logic                             match_valid,
    output logic                             match,
    output logic [MAX_STR_ADD-1:0]           match_index
);

    localparam int IDX_W = $clog2(NUM_SLAVE);

    state_t                       state;
    logic [MAX_STR_ADD:0]         str_cnt;
    logic [MAX_PAT_ADD:0]         pat_cnt;
    logic [MAX_STR_ADD:0]         base;
    logic [MAX_STR_ADD:0]         last;
    logic                         str_loaded;
    logic                         launch_ok;

    logic                         is_str_byte;
    logic                         is_pat_byte;
    logic [MAX_STR_ADD:0]         commit_str;
    logic [MAX_STR_ADD:0]         commit_pat;
    logic                         fits;
    logic [MAX_STR_ADD:0]         sched_base;
    logic [MAX_STR_ADD:0]         sched_last;
    logic [NUM_SLAVE-1:0]         sched_en;
    logic [NUM_SLAVE*MAX_STR_ADD-1:0] sched_off;

    logic                         arb_clear;
    logic                         arb_collect;
    logic                         all_done;
    logic                         any_hit;
    logic [IDX_W-1:0]             hit_idx;

    assign is_str_byte = in_valid && in_is_str;
    assign is_pat_byte = in_valid && !in_is_str && in_is_pat;

    // A pattern-only job reuses the previously committed string.
    assign commit_str = str_loaded ? str_cnt : str_len;
    assign commit_pat = (MAX_STR_ADD + 1)'(pat_cnt);
    assign fits       = commit_pat <= commit_str;

    // The first round is scheduled on leaving LOAD_PAT, later ones from WAIT.
    assign sched_base = (state == ST_WAIT) ? base + ROUND_STEP : '0;
    assign sched_last = (state == ST_WAIT) ? last : commit_str - commit_pat;

    always_comb begin
        logic [MAX_STR_ADD:0] slot;
        slot      = '0;
        sched_en  = '0;
        sched_off = '0;
        for (int k = 0; k < NUM_SLAVE; k++) begin
            slot = sched_base + (MAX_STR_ADD + 1)'(k);
            sched_en[k] = slot <= sched_last;
            sched_off[k*MAX_STR_ADD +: MAX_STR_ADD] = slot[MAX_STR_ADD-1:0];
        end
    end

    assign arb_clear   = (state == ST_LAUNCH);
    assign arb_collect = (state == ST_WAIT);

    sme_hit_arbiter #(
        .N_SLV (NUM_SLAVE),
        .IDX_W (IDX_W)
    ) u_hit_arbiter (
        .clk      (clk),
        .reset    (reset),
        .clear    (arb_clear),
        .collect  (arb_collect),
        .en       (slv_en),
        .done     (slv_done),
        .hit      (slv_hit),
        .all_done (all_done),
        .any_hit  (any_hit),
        .hit_idx  (hit_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b1;
            mem_write   <= 1'b0;
            mem_sel     <= MEM_SEL_STR;
            mem_data    <= '0;
            str_len     <= '0;
            pat_len     <= '0;
            str_cnt     <= '0;
            pat_cnt     <= '0;
            base        <= '0;
            last        <= '0;
            str_loaded  <= 1'b0;
            launch_ok   <= 1'b0;
            slv_start   <= 1'b0;
            slv_en      <= '0;
            slv_offset  <= '0;
            match_valid <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
        end else begin
            mem_write   <= 1'b0;
            slv_start   <= 1'b0;
            match_valid <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (is_str_byte) begin
                        state      <= ST_LOAD_STR;
                        str_cnt    <= (MAX_STR_ADD + 1)'(1);
                        str_loaded <= 1'b1;
                        mem_write  <= 1'b1;
                        mem_sel    <= MEM_SEL_STR;
                        mem_data   <= in_char;
                    end else if (is_pat_byte) begin
                        state      <= ST_LOAD_PAT;
                        pat_cnt    <= (MAX_PAT_ADD + 1)'(1);
                        str_loaded <= 1'b0;
                        mem_write  <= 1'b1;
                        mem_sel    <= MEM_SEL_PAT;
                        mem_data   <= in_char;
                    end
                end

                ST_LOAD_STR: begin
                    if (!in_valid) begin
                        state      <= ST_IDLE;
                        str_len    <= str_cnt;
                        str_loaded <= 1'b0;
                    end else if (in_is_str) begin
                        if (str_cnt < STR_FULL) begin
                            str_cnt   <= str_cnt + 1'b1;
                            mem_write <= 1'b1;
                            mem_sel   <= MEM_SEL_STR;
                            mem_data  <= in_char;
                        end
                    end else if (in_is_pat) begin
                        state     <= ST_LOAD_PAT;
                        pat_cnt   <= (MAX_PAT_ADD + 1)'(1);
                        mem_write <= 1'b1;
                        mem_sel   <= MEM_SEL_PAT;
                        mem_data  <= in_char;
                    end
                end

                ST_LOAD_PAT: begin
                    if (!in_valid) begin
                        state      <= ST_LAUNCH;
                        in_ready   <= 1'b0;
                        pat_len    <= pat_cnt;
                        str_len    <= commit_str;
                        str_loaded <= 1'b0;
                        base       <= '0;
                        last       <= sched_last;
                        launch_ok  <= fits;
                        slv_start  <= fits;
                        slv_en     <= fits ? sched_en : '0;
                        slv_offset <= sched_off;
                    end else if (is_pat_byte && pat_cnt < PAT_FULL) begin
                        pat_cnt   <= pat_cnt + 1'b1;
                        mem_write <= 1'b1;
                        mem_sel   <= MEM_SEL_PAT;
                        mem_data  <= in_char;
                    end
                end

                ST_LAUNCH: begin
                    if (launch_ok) begin
                        state <= ST_WAIT;
                    end else begin
                        state       <= ST_REPORT;
                        match_valid <= 1'b1;
                        match       <= 1'b0;
                        match_index <= '0;
                    end
                end

                ST_WAIT: begin
                    if (all_done) begin
                        if (any_hit) begin
                            state       <= ST_REPORT;
                            match_valid <= 1'b1;
                            match       <= 1'b1;
                            match_index <= base[MAX_STR_ADD-1:0] + MAX_STR_ADD'(hit_idx);
                            slv_en      <= '0;
                        end else if (sched_base > last) begin
                            state       <= ST_REPORT;
                            match_valid <= 1'b1;
                            match       <= 1'b0;
                            match_index <= '0;
                            slv_en      <= '0;
                        end else begin
                            state      <= ST_LAUNCH;
                            base       <= sched_base;
                            slv_start  <= 1'b1;
                            slv_en     <= sched_en;
                            slv_offset <= sched_off;
                        end
                    end
                end

                ST_REPORT: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
